// File: rtl/lifo_stack_if.sv
// Bus bundle for lifo_stack: push/pop handshake, data paths and status.
// The LIFO_STACK_PEEK_EN build adds the top_data/top_valid peek signals.
interface lifo_stack_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] data_in;
  logic              err_clear;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              full;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;
`ifdef LIFO_STACK_PEEK_EN
  logic [DATA_W-1:0] top_data;
  logic              top_valid;

  modport master (
    output push, pop, data_in, err_clear,
    input  data_out, out_valid, full, empty, count, overflow, underflow,
    input  top_data, top_valid
  );

  modport slave (
    input  push, pop, data_in, err_clear,
    output data_out, out_valid, full, empty, count, overflow, underflow,
    output top_data, top_valid
  );
`else
  modport master (
    output push, pop, data_in, err_clear,
    input  data_out, out_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  push, pop, data_in, err_clear,
    output data_out, out_valid, full, empty, count, overflow, underflow
  );
`endif
endinterface

// File: rtl/lifo_stack.sv
// Parametrised LIFO stack with sticky overflow/underflow flags and
// simultaneous push/pop. Optional peek port under LIFO_STACK_PEEK_EN.
module lifo_stack #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           reset,
  lifo_stack_if.slave    bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [CNT_W-1:0]  count_q, count_d, count_m1;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              out_valid_q, out_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [AW-1:0]     top_addr;
  logic              push_refused;
  logic              pop_refused;

  assign count_m1 = count_q - CNT_W'(1);
  assign top_addr = AW'(count_m1);

  always_comb begin
    count_d      = count_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = AW'(count_q);
    push_refused = 1'b0;
    pop_refused  = 1'b0;

    if (bus.push && !bus.pop) begin
      if (full_q) begin
        push_refused = 1'b1;
      end else begin
        wr_en   = 1'b1;
        count_d = count_q + CNT_W'(1);
      end
    end else if (bus.pop && !bus.push) begin
      if (empty_q) begin
        pop_refused = 1'b1;
      end else begin
        data_out_d  = mem[top_addr];
        out_valid_d = 1'b1;
        count_d     = count_m1;
      end
    end else if (bus.push && bus.pop) begin
      out_valid_d = 1'b1;
      if (empty_q) begin
        // Nothing stored: the pushed word passes straight through.
        data_out_d = bus.data_in;
      end else begin
        data_out_d = mem[top_addr];
        wr_en      = 1'b1;
        wr_addr    = top_addr;
      end
    end

    // A fresh refusal outranks err_clear in the same cycle.
    overflow_d  = (overflow_q  & ~bus.err_clear) | push_refused;
    underflow_d = (underflow_q & ~bus.err_clear) | pop_refused;
    full_d      = (count_d == CNT_MAX);
    empty_d     = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is never cleared; reset only blocks the write of that cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem[wr_addr] <= bus.data_in;
    end
  end

  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

`ifdef LIFO_STACK_PEEK_EN
  assign bus.top_data  = empty_q ? '0 : mem[top_addr];
  assign bus.top_valid = ~empty_q;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Directed self-checking bench for lifo_stack at DATA_W=8, DEPTH=4.
module tb_lifo_stack;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  lifo_stack_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample just after the clock edge.
  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic clr, input logic rst);
    @(negedge clk);
    bus.push      = p;
    bus.pop       = q;
    bus.data_in   = d;
    bus.err_clear = clr;
    reset         = rst;
    @(posedge clk);
    #1;
    $display("step push=%0d pop=%0d din=%02h clr=%0d rst=%0d -> dout=%02h ov=%0d cnt=%0d full=%0d empty=%0d of=%0d uf=%0d",
             p, q, d, clr, rst, bus.data_out, bus.out_valid, bus.count,
             bus.full, bus.empty, bus.overflow, bus.underflow);
  endtask

  task automatic push_w(input logic [7:0] d);
    step(1'b1, 1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic pop_w();
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.data_in   = 8'h00;
    bus.err_clear = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_dout", bus.data_out, 8'h00);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_of", bus.overflow, 0);
    chk("rst_uf", bus.underflow, 0);
    idle();

    // 1: fill then drain
    push_w(8'h11); chk("t1_cnt1", bus.count, 1); chk("t1_empty1", bus.empty, 0);
    push_w(8'h22); chk("t1_cnt2", bus.count, 2);
`ifdef LIFO_STACK_PEEK_EN
    chk("t1_top", bus.top_data, 8'h22);
    chk("t1_topv", bus.top_valid, 1);
`endif
    push_w(8'h33); chk("t1_cnt3", bus.count, 3); chk("t1_full3", bus.full, 0);
    push_w(8'h44); chk("t1_cnt4", bus.count, 4); chk("t1_full4", bus.full, 1);
    pop_w(); chk("t1_pop44", bus.data_out, 8'h44); chk("t1_v44", bus.out_valid, 1);
    chk("t1_cnt_a", bus.count, 3); chk("t1_full_a", bus.full, 0);
    pop_w(); chk("t1_pop33", bus.data_out, 8'h33); chk("t1_v33", bus.out_valid, 1);
    pop_w(); chk("t1_pop22", bus.data_out, 8'h22); chk("t1_v22", bus.out_valid, 1);
    pop_w(); chk("t1_pop11", bus.data_out, 8'h11); chk("t1_v11", bus.out_valid, 1);
    chk("t1_empty", bus.empty, 1); chk("t1_cnt0", bus.count, 0);
    idle(); chk("t1_vpulse", bus.out_valid, 0); chk("t1_dhold", bus.data_out, 8'h11);

    // 2: overflow on full stack
    push_w(8'h11); push_w(8'h22); push_w(8'h33); push_w(8'h44);
    push_w(8'h55);
    chk("t2_of", bus.overflow, 1); chk("t2_cnt", bus.count, 4); chk("t2_full", bus.full, 1);
    pop_w(); chk("t2_pop44", bus.data_out, 8'h44); chk("t2_cnt3", bus.count, 3);
    chk("t2_of_sticky", bus.overflow, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); chk("t2_of_clr", bus.overflow, 0);
    pop_w(); chk("t2_pop33", bus.data_out, 8'h33);
    pop_w(); chk("t2_pop22", bus.data_out, 8'h22);
    pop_w(); chk("t2_pop11", bus.data_out, 8'h11); chk("t2_empty", bus.empty, 1);

    // 3: underflow on empty stack
    pop_w();
    chk("t3_uf", bus.underflow, 1); chk("t3_valid", bus.out_valid, 0);
    chk("t3_dhold", bus.data_out, 8'h11); chk("t3_cnt", bus.count, 0);
    chk("t3_of", bus.overflow, 0);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0); chk("t3_new_err_wins", bus.underflow, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); chk("t3_uf_clr", bus.underflow, 0);

    // 4: replace top with simultaneous push/pop
    push_w(8'h11); push_w(8'h22);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("t4_dout", bus.data_out, 8'h22); chk("t4_valid", bus.out_valid, 1);
    chk("t4_cnt", bus.count, 2); chk("t4_of", bus.overflow, 0); chk("t4_uf", bus.underflow, 0);
    pop_w(); chk("t4_pop99", bus.data_out, 8'h99); chk("t4_cnt1", bus.count, 1);
    pop_w(); chk("t4_pop11", bus.data_out, 8'h11); chk("t4_cnt0", bus.count, 0);

    // 4b: replace top while full
    push_w(8'hA1); push_w(8'hA2); push_w(8'hA3); push_w(8'hA4);
    step(1'b1, 1'b1, 8'hB4, 1'b0, 1'b0);
    chk("t4b_dout", bus.data_out, 8'hA4); chk("t4b_cnt", bus.count, 4);
    chk("t4b_of", bus.overflow, 0); chk("t4b_full", bus.full, 1);
    pop_w(); chk("t4b_popB4", bus.data_out, 8'hB4);
    pop_w(); chk("t4b_popA3", bus.data_out, 8'hA3);
    pop_w(); chk("t4b_popA2", bus.data_out, 8'hA2);
    pop_w(); chk("t4b_popA1", bus.data_out, 8'hA1);

    // 5: bypass on empty stack
    step(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
    chk("t5_dout", bus.data_out, 8'h7E); chk("t5_valid", bus.out_valid, 1);
    chk("t5_cnt", bus.count, 0); chk("t5_empty", bus.empty, 1);
    chk("t5_of", bus.overflow, 0); chk("t5_uf", bus.underflow, 0);

    // 6: reset with a push in flight
    pop_w(); chk("t6_uf_pre", bus.underflow, 1);
    push_w(8'h01); push_w(8'h02); push_w(8'h03); chk("t6_cnt3", bus.count, 3);
    step(1'b1, 1'b0, 8'h04, 1'b0, 1'b1);
    chk("t6_cnt", bus.count, 0); chk("t6_empty", bus.empty, 1); chk("t6_full", bus.full, 0);
    chk("t6_uf", bus.underflow, 0); chk("t6_of", bus.overflow, 0);
    chk("t6_dout", bus.data_out, 8'h00); chk("t6_valid", bus.out_valid, 0);
`ifdef LIFO_STACK_PEEK_EN
    chk("t6_topv", bus.top_valid, 0);
    chk("t6_top", bus.top_data, 8'h00);
`endif
    idle(); chk("t6_cnt_after", bus.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
